pipeline_sink_counted: RTL

//  Multi-channel successor to the plain pipeline sink. Each channel either passes a ready/valid

---
 rtl/pipeline_sink_counted.sv | 110 +++++++++++
 1 files changed

// File: rtl/pipeline_sink_counted.sv
// pipeline_sink_counted
// Per-channel ready/valid pass-through that can instead sink items, either
// unconditionally (sink_forever) or for a loadable number of handshakes
// (drop counter). Sunk handshakes are counted in a saturating tally.
// Channels are fully independent; the handshake path is purely combinational
// and holds no data, so nothing is duplicated or stranded on a mode change.

module pipeline_sink_counted #(
    parameter int WORD_WIDTH    = 8,
    parameter int CHANNEL_COUNT = 1,
    parameter int COUNT_WIDTH   = 8,
    parameter int TALLY_WIDTH   = 16
) (
    input  logic                                 clock,
    input  logic                                 clear,
    input  logic [CHANNEL_COUNT-1:0]             sink_forever,
    input  logic [CHANNEL_COUNT-1:0]             drop_load,
    input  logic [CHANNEL_COUNT*COUNT_WIDTH-1:0] drop_count,
    output logic [CHANNEL_COUNT*COUNT_WIDTH-1:0] drop_pending,
    output logic [CHANNEL_COUNT-1:0]             sinking,
    input  logic [CHANNEL_COUNT-1:0]             tally_clear,
    output logic [CHANNEL_COUNT*TALLY_WIDTH-1:0] dropped_tally,
    input  logic [CHANNEL_COUNT-1:0]             input_valid,
    output logic [CHANNEL_COUNT-1:0]             input_ready,
    input  logic [CHANNEL_COUNT*WORD_WIDTH-1:0]  input_data,
    output logic [CHANNEL_COUNT-1:0]             output_valid,
    input  logic [CHANNEL_COUNT-1:0]             output_ready,
    output logic [CHANNEL_COUNT*WORD_WIDTH-1:0]  output_data
);

    localparam logic [COUNT_WIDTH-1:0] COUNT_ZERO = '0;
    localparam logic [COUNT_WIDTH-1:0] COUNT_ONE  = COUNT_WIDTH'(1'b1);
    localparam logic [TALLY_WIDTH-1:0] TALLY_ZERO = '0;
    localparam logic [TALLY_WIDTH-1:0] TALLY_ONE  = TALLY_WIDTH'(1'b1);
    localparam logic [TALLY_WIDTH-1:0] TALLY_MAX  = '1;
    localparam logic [WORD_WIDTH-1:0]  WORD_ZERO  = '0;

    for (genvar ch = 0; ch < CHANNEL_COUNT; ch++) begin : g_channel

        logic [COUNT_WIDTH-1:0] pending_r;
        logic [TALLY_WIDTH-1:0] tally_r;
        logic                   sinking_s;
        logic                   sunk_s;
        logic                   in_ready_s;
        logic                   out_valid_s;
        logic [WORD_WIDTH-1:0]  out_data_s;

        // Mode decision and sunk-handshake detection for this channel.
        always_comb begin
            sinking_s = 1'b0;
            sunk_s    = 1'b0;
            if (sink_forever[ch] || (pending_r != COUNT_ZERO)) begin
                sinking_s = 1'b1;
            end else begin
                sinking_s = 1'b0;
            end
            sunk_s = sinking_s & input_valid[ch];
        end

        // Handshake steering: pass straight through, or accept and discard.
        always_comb begin
            in_ready_s  = 1'b0;
            out_valid_s = 1'b0;
            out_data_s  = WORD_ZERO;
            if (sinking_s) begin
                in_ready_s  = 1'b1;
                out_valid_s = 1'b0;
                out_data_s  = WORD_ZERO;
            end else begin
                in_ready_s  = output_ready[ch];
                out_valid_s = input_valid[ch];
                out_data_s  = input_data[ch*WORD_WIDTH +: WORD_WIDTH];
            end
        end

        // Drop counter: a load overrides the decrement of the same cycle.
        always_ff @(posedge clock or posedge clear) begin
            if (clear) begin
                pending_r <= COUNT_ZERO;
            end else if (drop_load[ch]) begin
                pending_r <= drop_count[ch*COUNT_WIDTH +: COUNT_WIDTH];
            end else if (sunk_s && (pending_r != COUNT_ZERO)) begin
                pending_r <= pending_r - COUNT_ONE;
            end else begin
                pending_r <= pending_r;
            end
        end

        // Saturating tally of sunk handshakes; a clear still counts a same-cycle item.
        always_ff @(posedge clock or posedge clear) begin
            if (clear) begin
                tally_r <= TALLY_ZERO;
            end else if (tally_clear[ch]) begin
                tally_r <= sunk_s ? TALLY_ONE : TALLY_ZERO;
            end else if (sunk_s && (tally_r != TALLY_MAX)) begin
                tally_r <= tally_r + TALLY_ONE;
            end else begin
                tally_r <= tally_r;
            end
        end

        assign sinking[ch]                                   = sinking_s;
        assign input_ready[ch]                               = in_ready_s;
        assign output_valid[ch]                              = out_valid_s;
        assign output_data[ch*WORD_WIDTH +: WORD_WIDTH]      = out_data_s;
        assign drop_pending[ch*COUNT_WIDTH +: COUNT_WIDTH]   = pending_r;
        assign dropped_tally[ch*TALLY_WIDTH +: TALLY_WIDTH]  = tally_r;
    end

endmodule
